// File: rtl/guess_entry.sv
// guess_entry: edits a 4-peg guess from buttons, commits it, then serially scores it against the secret
module guess_entry #(
  parameter int MAX_TURNS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_select,
  input  logic [2:0] i_secret3,
  input  logic [2:0] i_secret2,
  input  logic [2:0] i_secret1,
  input  logic [2:0] i_secret0,
  output logic [2:0] o_guess3,
  output logic [2:0] o_guess2,
  output logic [2:0] o_guess1,
  output logic [2:0] o_guess0,
  output logic [1:0] o_cursor,
  output logic       o_commit,
  output logic [2:0] o_black,
  output logic [2:0] o_white,
  output logic       o_score_valid,
  output logic [3:0] o_turn,
  output logic       o_won,
  output logic       o_game_over
);
  typedef enum logic [2:0] {EDIT, COMMIT, EXACT, PARTIAL, DONE} state_t;
  state_t r_state;
  logic [3:0][2:0] r_g, w_s;
  logic [1:0] r_cursor;
  logic [2:0] r_idx, r_black_acc, r_tot_acc;
  logic [2:0] w_gc, w_sc, w_min, w_tot_next, w_black_next;
  logic [3:0] w_turn_next;
  logic       w_go;
  assign w_s = {i_secret3, i_secret2, i_secret1, i_secret0};
  assign {o_guess3, o_guess2, o_guess1, o_guess0} = r_g;
  assign o_cursor = r_cursor;
  // r_idx is the peg index in EXACT and the colour being counted in PARTIAL
  always_comb begin
    w_gc = '0;
    w_sc = '0;
    for (int k = 0; k < 4; k++) begin
      w_gc = w_gc + 3'(r_g[k] == r_idx);
      w_sc = w_sc + 3'(w_s[k] == r_idx);
    end
    w_min = (w_gc < w_sc) ? w_gc : w_sc;
    w_tot_next = r_tot_acc + w_min;
    w_black_next = r_black_acc + 3'(r_g[r_idx[1:0]] == w_s[r_idx[1:0]]);
    w_turn_next = o_turn + 4'd1;
    w_go = (r_black_acc == 3'd4) || (w_turn_next == 4'(MAX_TURNS));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EDIT;
      r_g <= '0;
      r_cursor <= '0;
      r_idx <= '0;
      r_black_acc <= '0;
      r_tot_acc <= '0;
      o_commit <= 1'b0;
      o_black <= '0;
      o_white <= '0;
      o_score_valid <= 1'b0;
      o_turn <= '0;
      o_won <= 1'b0;
      o_game_over <= 1'b0;
    end else begin
      o_commit <= 1'b0;
      case (r_state)
        EDIT: if (!i_mode) begin
          if (i_btn_select) begin
            r_state <= COMMIT;
            o_commit <= 1'b1;
            o_score_valid <= 1'b0;
          end else if (i_btn_up) r_g[r_cursor] <= r_g[r_cursor] + 3'd1;
          else if (i_btn_down) r_g[r_cursor] <= r_g[r_cursor] - 3'd1;
          else if (i_btn_left) r_cursor <= r_cursor + 2'd1;
          else if (i_btn_right) r_cursor <= r_cursor - 2'd1;
        end
        COMMIT: begin
          r_state <= EXACT;
          r_idx <= '0;
          r_black_acc <= '0;
          r_tot_acc <= '0;
        end
        EXACT: begin
          r_black_acc <= w_black_next;
          r_idx <= (r_idx == 3'd3) ? 3'd0 : r_idx + 3'd1;
          if (r_idx == 3'd3) r_state <= PARTIAL;
        end
        PARTIAL: begin
          r_tot_acc <= w_tot_next;
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            o_black <= r_black_acc;
            o_white <= w_tot_next - r_black_acc;
            o_score_valid <= 1'b1;
            o_turn <= w_turn_next;
            o_won <= (r_black_acc == 3'd4);
            o_game_over <= w_go;
            r_state <= w_go ? DONE : EDIT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed stimulus with a commit/score scoreboard checked by a negedge monitor
module tb_guess_entry;
  logic clk = 0, rst = 1, mode = 0;
  logic bl = 0, br = 0, bu = 0, bd = 0, bs = 0;
  logic [2:0] s3 = 0, s2 = 0, s1 = 0, s0 = 0;
  logic [2:0] g3, g2, g1, g0, black, white;
  logic [1:0] cursor;
  logic commit, score_valid, won, game_over;
  logic [3:0] turn;
  int cyc = 0, n_chk = 0, n_pass = 0, last_t = 0;
  logic sv_prev = 0;
  logic [11:0] m_g = 0;
  typedef struct {logic [11:0] g; int t;} cexp_t;
  typedef struct {int b; int w; int tn; int wn; int go; int t;} sexp_t;
  cexp_t q_c[$];
  sexp_t q_s[$];
  wire [11:0] g_all = {g3, g2, g1, g0};

  guess_entry dut (
    .clk(clk), .rst(rst), .i_mode(mode),
    .i_btn_left(bl), .i_btn_right(br), .i_btn_up(bu), .i_btn_down(bd), .i_btn_select(bs),
    .i_secret3(s3), .i_secret2(s2), .i_secret1(s1), .i_secret0(s0),
    .o_guess3(g3), .o_guess2(g2), .o_guess1(g1), .o_guess0(g0),
    .o_cursor(cursor), .o_commit(commit), .o_black(black), .o_white(white),
    .o_score_valid(score_valid), .o_turn(turn), .o_won(won), .o_game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && commit) begin
      if (q_c.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_commit: got commit expected none (cycle %0d)", cyc);
      end else begin
        cexp_t e;
        e = q_c.pop_front();
        chk("commit_guess", int'(g_all), int'(e.g));
        chk("commit_latency", cyc, e.t);
      end
    end
    if (!rst && score_valid && !sv_prev) begin
      if (q_s.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_score: got score_valid expected none (cycle %0d)", cyc);
      end else begin
        sexp_t e;
        e = q_s.pop_front();
        chk("black", int'(black), e.b);
        chk("white", int'(white), e.w);
        chk("turn", int'(turn), e.tn);
        chk("won", int'(won), e.wn);
        chk("game_over", int'(game_over), e.go);
        chk("score_latency", cyc, e.t + 13);
      end
    end
    sv_prev = score_valid;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_g = 0;
    @(negedge clk);
    chk("reset_outputs", int'({g_all, cursor, commit, black, white, score_valid, turn, won, game_over}), 0);
  endtask

  task automatic press(input int b);
    @(posedge clk); #1;
    if (b == 0) bl = 1; else if (b == 1) br = 1; else if (b == 2) bu = 1; else bd = 1;
    @(posedge clk); #1 {bl, br, bu, bd} = 0;
  endtask

  task automatic select(input bit exp_commit, input logic [11:0] g);
    @(posedge clk); #1 bs = 1;
    last_t = cyc + 1;
    if (exp_commit) q_c.push_back('{g, last_t});
    @(posedge clk); #1 bs = 0;
  endtask

  task automatic exp_score(input int b, input int w, input int tn, input int wn, input int go);
    q_s.push_back('{b, w, tn, wn, go, last_t});
  endtask

  // assumes cursor at peg0 on entry; leaves it at peg0
  task automatic set_guess(input logic [11:0] v);
    for (int p = 0; p < 4; p++) begin
      logic [2:0] d;
      d = v[3*p +: 3] - m_g[3*p +: 3];
      repeat (int'(d)) press(2);
      press(0);
    end
    m_g = v;
  endtask

  task automatic drain(input string name);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk(name, q_c.size() + q_s.size(), 0);
  endtask

  initial begin
    // 1: edit pegs 0 and 1, peg1 wraps after 9 ups
    do_reset();
    repeat (3) press(2);
    press(0);
    repeat (9) press(2);
    @(negedge clk);
    chk("t1_guess", int'(g_all), int'({3'd0, 3'd0, 3'd1, 3'd3}));
    chk("t1_cursor", int'(cursor), 1);
    // 2: right wraps 0->3, down wraps 0->7
    press(1);
    @(negedge clk) chk("t2_cursor0", int'(cursor), 0);
    press(1); press(1);
    @(negedge clk) chk("t2_cursor2", int'(cursor), 2);
    press(3);
    @(negedge clk) chk("t2_guess", int'(g_all), int'({3'd0, 3'd7, 3'd1, 3'd3}));
    // 3: partial score, buttons during scoring dropped
    do_reset();
    {s3, s2, s1, s0} = {3'd5, 3'd2, 3'd2, 3'd1};
    set_guess({3'd2, 3'd2, 3'd1, 3'd1});
    select(1, m_g);
    exp_score(2, 1, 1, 0, 0);
    {bu, bl, bs} = 3'b111;
    repeat (13) @(posedge clk);
    #1 {bu, bl, bs} = 0;
    drain("t3_drain");
    chk("t3_guess_hold", int'(g_all), int'(m_g));
    chk("t3_cursor_hold", int'(cursor), 0);
    chk("t3_score_valid_hold", int'(score_valid), 1);
    // 4: exact win, then frozen
    do_reset();
    {s3, s2, s1, s0} = {3'd3, 3'd6, 3'd0, 3'd4};
    set_guess({3'd3, 3'd6, 3'd0, 3'd4});
    select(1, m_g);
    exp_score(4, 0, 1, 1, 1);
    drain("t4_drain");
    press(2);
    select(0, m_g);
    drain("t4_done_drain");
    chk("t4_guess_frozen", int'(g_all), int'(m_g));
    chk("t4_game_over", int'(game_over), 1);
    // 5: eight losing turns end the game
    do_reset();
    {s3, s2, s1, s0} = {3'd7, 3'd7, 3'd7, 3'd7};
    for (int k = 1; k <= 8; k++) begin
      select(1, m_g);
      exp_score(0, 0, k, 0, k == 8 ? 1 : 0);
      drain("t5_drain");
    end
    select(0, m_g);
    drain("t5_ninth");
    chk("t5_turn", int'(turn), 8);
    chk("t5_game_over", int'(game_over), 1);
    chk("t5_won", int'(won), 0);
    // 6: history mode ignores buttons; reset mid-score
    do_reset();
    {s3, s2, s1, s0} = {3'd5, 3'd2, 3'd2, 3'd1};
    mode = 1;
    press(2); press(0);
    select(0, m_g);
    drain("t6_mode_drain");
    chk("t6_mode_hold", int'({g_all, cursor}), 0);
    mode = 0;
    press(2);
    m_g = 12'd1;
    @(negedge clk) chk("t6_guess", int'(g_all), 1);
    select(1, m_g);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_reset_mid", int'({g_all, cursor, commit, black, white, score_valid, turn, won, game_over}), 0);
    drain("t6_drain");
    chk("t6_no_score", int'(score_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
